// File: rtl/uart_tx_queue_if.sv
// Producer-side handshake and uart_tx-side outputs of uart_tx_queue.
// The DUT connects to the slave modport. The producer or bench connects to the master modport.
interface uart_tx_queue_if #(
  parameter int DEPTH = 16
) ();
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic [LVL_W-1:0] level;
  logic             overflow;

  modport slave (
    input  in_data, in_valid,
    output in_ready, tx_start, tx_data, level, overflow
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, tx_start, tx_data, level, overflow
  );
endinterface

// File: rtl/uart_tx_queue.sv
// Byte FIFO that paces bytes into a uart_tx: one tx_start pulse per FRAME_CYCLES+1 clocks.
// Define UART_TX_QUEUE_OVERFLOW_EN to build the sticky overflow flag; otherwise overflow is tied to 0.
module uart_tx_queue #(
  parameter int DEPTH        = 16,
  parameter int FRAME_CYCLES = 4340
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(FRAME_CYCLES);

  typedef enum logic {IDLE, PACE} state_e;

  state_e             state_q, state_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [7:0]         mem_q [DEPTH];

  logic full;
  logic push;
  logic pop;

  // A pop in the same cycle does not open a slot: acceptance depends only on the current level.
  assign full          = (level_q == LVL_W'(DEPTH));
  assign push          = bus.in_valid && !full;
  assign bus.in_ready  = !full;
  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.level     = level_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          pop        = 1'b1;
          tx_start_d = 1'b1;
          tx_data_d  = mem_q[rd_ptr_q];
          cnt_d      = CNT_W'(FRAME_CYCLES - 1);
          state_d    = PACE;
        end
      end
      PACE: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      level_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Storage carries no reset; the pointers and level define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

`ifdef UART_TX_QUEUE_OVERFLOW_EN
  logic overflow_q, overflow_d;

  assign overflow_d   = overflow_q | (bus.in_valid & full);
  assign bus.overflow = overflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end
`else
  assign bus.overflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue with DEPTH=4, FRAME_CYCLES=20.
// Accepted bytes are queued as expectations, and a negedge monitor checks each tx_start pulse against that queue.
module tb_uart_tx_queue;
  localparam int DEPTH = 4;
  localparam int FC    = 20;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;
  int   exp_ovf;
  logic [7:0] sb_q [$];
  int   pulse_q [$];

  uart_tx_queue_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_queue #(.DEPTH(DEPTH), .FRAME_CYCLES(FC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d, input bit expect_out);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    if (expect_out) sb_q.push_back(d);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Monitor: every tx_start pulse must carry the oldest outstanding expected byte.
  always @(negedge clk) begin
    if (rst_n && bus.tx_start) begin
      pulse_q.push_back(cyc);
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", int'(bus.tx_data), -1);
      end else begin
        check("tx_data_order", int'(bus.tx_data), int'(sb_q.pop_front()));
      end
    end
  end

  initial begin
`ifdef UART_TX_QUEUE_OVERFLOW_EN
    exp_ovf = 1;
`else
    exp_ovf = 0;
`endif
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst_n = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    #2;
    check("rst_level", int'(bus.level), 0);
    check("rst_tx_start", int'(bus.tx_start), 0);
    check("rst_tx_data", int'(bus.tx_data), 0);
    check("rst_overflow", int'(bus.overflow), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("in_ready_after_rst", int'(bus.in_ready), 1);

    // Single byte: the pulse comes one edge after acceptance.
    push_byte(8'h41, 1'b1);
    check("t1_level_after_push", int'(bus.level), 1);
    check("t1_start_not_yet", int'(bus.tx_start), 0);
    tick();
    check("t1_start_latency", int'(bus.tx_start), 1);
    check("t1_tx_data", int'(bus.tx_data), 8'h41);
    check("t1_level_zero", int'(bus.level), 0);
    tick();
    check("t1_pulse_one_cycle", int'(bus.tx_start), 0);
    repeat (25) tick();

    // Back-to-back burst: pulses must be FRAME_CYCLES+1 apart.
    pulse_q.delete();
    for (int i = 1; i <= 4; i++) push_byte(8'(i), 1'b1);
    repeat (90) tick();
    check("t2_pulse_count", pulse_q.size(), 4);
    for (int i = 1; i < 4 && i < pulse_q.size(); i++)
      check("t2_pulse_gap", pulse_q[i] - pulse_q[i-1], FC + 1);

    // Fill to full while pacing, then hold in_valid high with 0xFF.
    for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i), 1'b1);
    check("t3_level_full", int'(bus.level), 4);
    check("t3_in_ready_full", int'(bus.in_ready), 0);
    bus.in_data  = 8'hFF;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_in_ready_held", int'(bus.in_ready), 0);
      check("t3_level_held", int'(bus.level), 4);
    end
    bus.in_valid = 1'b0;
    check("t3_overflow", int'(bus.overflow), exp_ovf);
    repeat (110) tick();
    check("t3_drained", int'(bus.level), 0);

    // Nine paced bytes across pointer wrap-around.
    for (int i = 0; i < 9; i++) begin
      check("t4_in_ready", int'(bus.in_ready), 1);
      push_byte(8'h60 + 8'(i), 1'b1);
      repeat (14) tick();
    end
    repeat (150) tick();
    check("t4_drained", int'(bus.level), 0);

    // Push coinciding with a pop at level 2.
    push_byte(8'hB1, 1'b1);
    push_byte(8'hB2, 1'b1);
    push_byte(8'hB3, 1'b1);
    repeat (19) tick();
    check("t5_level_before", int'(bus.level), 2);
    check("t5_no_start_yet", int'(bus.tx_start), 0);
    push_byte(8'hAA, 1'b1);
    check("t5_pop_edge", int'(bus.tx_start), 1);
    check("t5_level_same", int'(bus.level), 2);
    repeat (75) tick();

    // Reset mid-PACE with level 3: the queued bytes are discarded.
    push_byte(8'hC1, 1'b1);
    push_byte(8'hC2, 1'b0);
    push_byte(8'hC3, 1'b0);
    push_byte(8'hC4, 1'b0);
    check("t6_level_three", int'(bus.level), 3);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("t6_rst_tx_start", int'(bus.tx_start), 0);
    check("t6_rst_tx_data", int'(bus.tx_data), 0);
    check("t6_rst_level", int'(bus.level), 0);
    check("t6_rst_overflow", int'(bus.overflow), 0);
    tick();
    rst_n = 1'b1;
    check("t6_in_ready", int'(bus.in_ready), 1);
    pulse_q.delete();
    repeat (40) tick();
    check("t6_no_pulses", pulse_q.size(), 0);
    check("t6_level_idle", int'(bus.level), 0);
    push_byte(8'hD5, 1'b1);
    repeat (25) tick();
    check("t6_new_pulse", pulse_q.size(), 1);

    check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
